// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants: RX state codes, parity encodings, RF_DI field indices
package uart_pkg;

    localparam logic [3:0] pRxIdle  = 4'd0;
    localparam logic [3:0] pRxStart = 4'd1;
    localparam logic [3:0] pRxD0    = 4'd2;
    localparam logic [3:0] pRxD1    = 4'd3;
    localparam logic [3:0] pRxD2    = 4'd4;
    localparam logic [3:0] pRxD3    = 4'd5;
    localparam logic [3:0] pRxD4    = 4'd6;
    localparam logic [3:0] pRxD5    = 4'd7;
    localparam logic [3:0] pRxD6    = 4'd8;
    localparam logic [3:0] pRxD7    = 4'd9;
    localparam logic [3:0] pRxPar   = 4'd10;
    localparam logic [3:0] pRxStop  = 4'd11;
    localparam logic [3:0] pRxBrk   = 4'd12;

    localparam logic [1:0] PAR_ODD  = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ZERO = 2'b10;
    localparam logic [1:0] PAR_ONE  = 2'b11;

    localparam int RF_BRK = 10;
    localparam int RF_FE  = 9;
    localparam int RF_PE  = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - multi-flop synchroniser for the asynchronous RxD pin, resets to idle-high
module uart_rx_sync #(
    parameter int pSyncLen = 2
) (
    input  logic Clk,
    input  logic Rst,
    input  logic RxD,
    output logic RxDs
);

    logic [pSyncLen-1:0] sff;

    always_ff @(posedge Clk) begin
        if (Rst) sff <= '1;
        else     sff <= {sff[pSyncLen-2:0], RxD};
    end

    assign RxDs = sff[pSyncLen-1];

endmodule

// File: rtl/uart_rxsm.sv
// rtl/uart_rxsm.sv - UART receive state machine: 16x oversampling, parity/stop checks, RF FIFO write
module uart_rxsm
    import uart_pkg::*;
#(
    parameter int         pSyncLen = 2,
    parameter logic [3:0] pMidPt   = 4'd7
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        CE_16x,
    input  logic        Len,
    input  logic        NumStop,
    input  logic        ParEn,
    input  logic [1:0]  Par,
    input  logic        RxD,
    input  logic        RF_FF,
    output logic        RF_WE,
    output logic [10:0] RF_DI,
    output logic        OE,
    output logic [3:0]  RxSM,
    output logic        RxIdle
);

    logic       rxds;
    logic [3:0] state, state_nxt;
    logic [3:0] cnt;
    logic [7:0] rsr;
    logic [7:0] data;
    logic       pe, par_bit, par_exp, wr_pend;
    logic       sample, start_det, fe_now, brk_now;
    logic [2:0] bit_idx;

    // The second stop bit is never checked; it simply looks like idle line.
    logic unused_numstop;
    assign unused_numstop = NumStop;

    uart_rx_sync #(.pSyncLen(pSyncLen)) u_sync (
        .Clk  (Clk),
        .Rst  (Rst),
        .RxD  (RxD),
        .RxDs (rxds)
    );

    assign sample    = CE_16x && (cnt == pMidPt);
    assign start_det = (state == pRxIdle) && CE_16x && !rxds;
    assign bit_idx   = 3'(state - pRxD0);
    assign data      = Len ? {1'b0, rsr[6:0]} : rsr;
    assign fe_now    = !rxds;
    assign brk_now   = fe_now && (data == 8'h00) && !par_bit;

    always_comb begin
        case (Par)
            PAR_ODD:  par_exp = ~^data;
            PAR_EVEN: par_exp = ^data;
            PAR_ZERO: par_exp = 1'b0;
            default:  par_exp = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) state <= pRxIdle;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            pRxIdle:  if (start_det) state_nxt = pRxStart;
            pRxStart: if (sample) state_nxt = rxds ? pRxIdle : pRxD0;
            pRxD0, pRxD1, pRxD2, pRxD3, pRxD4, pRxD5:
                      if (sample) state_nxt = state + 4'd1;
            pRxD6:    if (sample) state_nxt = !Len ? pRxD7 : (ParEn ? pRxPar : pRxStop);
            pRxD7:    if (sample) state_nxt = ParEn ? pRxPar : pRxStop;
            pRxPar:   if (sample) state_nxt = pRxStop;
            pRxStop:  if (sample) state_nxt = rxds ? pRxIdle : pRxBrk;
            pRxBrk:   if (CE_16x && rxds) state_nxt = pRxIdle;
            default:  state_nxt = pRxIdle;
        endcase
    end

    always_comb begin
        RF_WE  = wr_pend && !RF_FF;
        OE     = wr_pend && RF_FF;
        RxIdle = (state == pRxIdle);
        RxSM   = state;
    end

    // Datapath; the FIFO write is launched one Clk after the stop-bit sample.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt     <= '0;
            rsr     <= '0;
            pe      <= 1'b0;
            par_bit <= 1'b0;
            wr_pend <= 1'b0;
            RF_DI   <= '0;
        end else begin
            wr_pend <= 1'b0;
            if (start_det)   cnt <= '0;
            else if (CE_16x) cnt <= cnt + 4'd1;
            if (sample) begin
                case (state)
                    pRxStart: begin
                        rsr     <= '0;
                        pe      <= 1'b0;
                        par_bit <= 1'b0;
                    end
                    pRxD0, pRxD1, pRxD2, pRxD3, pRxD4, pRxD5, pRxD6, pRxD7:
                        rsr[bit_idx] <= rxds;
                    pRxPar: begin
                        par_bit <= rxds;
                        pe      <= (rxds != par_exp);
                    end
                    pRxStop: begin
                        RF_DI   <= {brk_now, fe_now, pe, data};
                        wr_pend <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rxsm.sv
// tb/tb_uart_rxsm.sv - self-checking bench for uart_rxsm: vector table, corner sequences, random frames
module tb_uart_rxsm;

    logic        Clk = 1'b0;
    logic        Rst, CE_16x, Len, NumStop, ParEn, RxD, RF_FF;
    logic [1:0]  Par;
    logic        RF_WE, OE, RxIdle;
    logic [10:0] RF_DI;
    logic [3:0]  RxSM;

    int checks = 0;
    int errors = 0;
    logic [10:0] wr_q[$];
    int oe_cycles = 0;
    int start_cycles = 0;

    typedef struct {
        logic [7:0]  data;
        bit          len;
        bit          paren;
        logic [1:0]  par;
        bit          pbit;
        bit          stopb;
        bit          ff;
        logic [10:0] exp_di;
    } vec_t;

    vec_t vecs[10];

    uart_rxsm #(.pSyncLen(2), .pMidPt(4'd7)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .CE_16x  (CE_16x),
        .Len     (Len),
        .NumStop (NumStop),
        .ParEn   (ParEn),
        .Par     (Par),
        .RxD     (RxD),
        .RF_FF   (RF_FF),
        .RF_WE   (RF_WE),
        .RF_DI   (RF_DI),
        .OE      (OE),
        .RxSM    (RxSM),
        .RxIdle  (RxIdle)
    );

    always #5 Clk = ~Clk;

    initial begin
        CE_16x = 1'b0;
        forever begin
            repeat (3) @(negedge Clk);
            CE_16x = 1'b1;
            @(negedge Clk);
            CE_16x = 1'b0;
        end
    end

    always @(negedge Clk) begin
        if (RF_WE === 1'b1) wr_q.push_back(RF_DI);
        if (OE === 1'b1) oe_cycles++;
        if (RxSM === 4'd1) start_cycles++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            while (!CE_16x) @(posedge Clk);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        ticks(16);
    endtask

    // Expected RF_DI from the frame-format rules, independent of any receiver timing.
    function automatic logic [10:0] model(input logic [7:0] data, input bit len, input bit paren,
                                          input logic [1:0] par, input bit pbit, input bit stopb);
        logic [7:0] d;
        int ones;
        bit want, pe, fe, brk;
        d = len ? (data & 8'h7F) : data;
        ones = $countones(d);
        case (par)
            2'b00:   want = (ones % 2 == 0);
            2'b01:   want = (ones % 2 == 1);
            2'b10:   want = 1'b0;
            default: want = 1'b1;
        endcase
        pe  = paren && (pbit != want);
        fe  = !stopb;
        brk = fe && (d == 8'h00) && !(paren && pbit);
        return {brk, fe, pe, d};
    endfunction

    task automatic run_frame(input string name, input logic [7:0] data, input bit len, input bit paren,
                             input logic [1:0] par, input bit pbit, input bit stopb, input bit ff,
                             input int gap, input logic [10:0] exp_di);
        int q0, oe0;
        Len = len; ParEn = paren; Par = par; RF_FF = ff;
        q0 = wr_q.size();
        oe0 = oe_cycles;
        send_bit(1'b0);
        for (int i = 0; i < (len ? 7 : 8); i++) send_bit(data[i]);
        if (paren) send_bit(pbit);
        send_bit(stopb);
        RxD = 1'b1;
        ticks(gap);
        chk({name, " writes"}, wr_q.size() - q0, ff ? 0 : 1);
        if (!ff && wr_q.size() > q0) chk({name, " RF_DI"}, {21'd0, wr_q[q0]}, {21'd0, exp_di});
        chk({name, " OE cycles"}, oe_cycles - oe0, ff ? 1 : 0);
        RF_FF = 1'b0;
    endtask

    initial begin
        int q0, s0;
        logic [7:0] rdata;
        bit rlen, rparen, rpbit, rstop, rff, rnstop;
        logic [1:0] rpar;
        int rgap;

        vecs[0] = '{8'hA5, 0, 0, 2'b00, 0, 1, 0, 11'h0A5};
        vecs[1] = '{8'h41, 1, 1, 2'b01, 0, 1, 0, 11'h041};
        vecs[2] = '{8'h41, 1, 1, 2'b01, 1, 1, 0, 11'h141};
        vecs[3] = '{8'h3C, 0, 0, 2'b00, 0, 0, 0, 11'h23C};
        vecs[4] = '{8'h55, 0, 0, 2'b00, 0, 1, 1, 11'h000};
        vecs[5] = '{8'h56, 0, 0, 2'b00, 0, 1, 0, 11'h056};
        vecs[6] = '{8'h07, 0, 1, 2'b00, 0, 1, 0, 11'h007};
        vecs[7] = '{8'h80, 0, 1, 2'b11, 0, 1, 0, 11'h180};
        vecs[8] = '{8'hC3, 1, 0, 2'b00, 0, 1, 0, 11'h043};
        vecs[9] = '{8'h00, 0, 1, 2'b10, 0, 0, 0, 11'h600};

        Rst = 1'b1; RxD = 1'b1; RF_FF = 1'b0; Len = 1'b0; NumStop = 1'b0; ParEn = 1'b0; Par = 2'b00;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset RxSM", RxSM, 4'd0);
        chk("reset RxIdle", RxIdle, 1'b1);
        chk("reset RF_WE", RF_WE, 1'b0);
        chk("reset OE", OE, 1'b0);
        chk("reset RF_DI", RF_DI, 11'h000);
        @(negedge Clk);
        Rst = 1'b0;
        ticks(20);

        for (int v = 0; v < 10; v++)
            run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].len, vecs[v].paren, vecs[v].par,
                      vecs[v].pbit, vecs[v].stopb, vecs[v].ff, 4, vecs[v].exp_di);
        chk("after FE frame RxIdle", RxIdle, 1'b1);

        // Line held low for 12 bit times: a single break record, then silence until line returns high.
        Len = 1'b0; ParEn = 1'b0;
        q0 = wr_q.size();
        RxD = 1'b0;
        ticks(192);
        chk("break writes", wr_q.size() - q0, 1);
        if (wr_q.size() > q0) chk("break RF_DI", {21'd0, wr_q[q0]}, 32'h600);
        chk("break state", RxSM, 4'd12);
        ticks(48);
        chk("break no rewrite", wr_q.size() - q0, 1);
        RxD = 1'b1;
        ticks(3);
        chk("break release idle", RxIdle, 1'b1);

        // Short low glitch: start state visited, rejected at mid-bit, nothing written.
        q0 = wr_q.size();
        s0 = start_cycles;
        RxD = 1'b0;
        ticks(4);
        RxD = 1'b1;
        ticks(20);
        chk("glitch saw start", start_cycles > s0, 1'b1);
        chk("glitch idle", RxIdle, 1'b1);
        chk("glitch writes", wr_q.size() - q0, 0);

        // Reset asserted while receiving data bit 3 of 0x81.
        q0 = wr_q.size();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        chk("pre-reset in D3", RxSM, 4'd5);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        chk("midframe reset RxSM", RxSM, 4'd0);
        chk("midframe reset RF_WE", RF_WE, 1'b0);
        @(negedge Clk);
        Rst = 1'b0;
        RxD = 1'b1;
        ticks(40);
        chk("midframe reset writes", wr_q.size() - q0, 0);
        run_frame("post-reset 0x81", 8'h81, 0, 0, 2'b00, 0, 1, 0, 4, 11'h081);

        for (int k = 0; k < 30; k++) begin
            rdata  = 8'($urandom);
            rlen   = 1'($urandom_range(0, 1));
            rparen = 1'($urandom_range(0, 1));
            rpar   = 2'($urandom_range(0, 3));
            rpbit  = 1'($urandom_range(0, 1));
            rstop  = ($urandom_range(0, 7) != 0);
            rff    = ($urandom_range(0, 5) == 0);
            rnstop = 1'($urandom_range(0, 1));
            rgap   = rstop ? int'($urandom_range(0, 3)) : int'($urandom_range(2, 4));
            if (rnstop) rgap += 16;
            NumStop = rnstop;
            run_frame($sformatf("rand%0d", k), rdata, rlen, rparen, rpar, rpbit, rstop, rff, rgap,
                      model(rdata, rlen, rparen, rpar, rpbit, rstop));
        end
        ticks(4);
        chk("final idle", RxIdle, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
